pit_mch_timer: RTL and testbench



---
 rtl/pit_mch_pkg.sv | 33 +++
 rtl/pit_mch_chan.sv | 92 +++++++++
 rtl/pit_mch_timer.sv | 99 +++++++++
 tb/tb_pit_mch_timer.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pit_mch_pkg.sv
// Shared register map, CTRL field layout and the per-channel control record
// for the multi-channel PIT.
package pit_mch_pkg;

  localparam int GSTAT_ADR  = 0;
  localparam int GSTART_ADR = 1;
  localparam int CH_BASE    = 2;
  localparam int CH_STRIDE  = 3;

  localparam int CTRL_CNT_EN   = 0;
  localparam int CTRL_IEN      = 1;
  localparam int CTRL_ONESHOT  = 4;
  localparam int CTRL_PRE_LSB  = 8;
  localparam int CTRL_PRE_MSB  = 11;

  typedef struct packed {
    logic [3:0] pre;
    logic       oneshot;
    logic       ien;
    logic       cnt_en;
  } ch_ctrl_t;

  function automatic logic [15:0] ctrl_to_word(input ch_ctrl_t c);
    logic [15:0] w;
    w = '0;
    w[CTRL_PRE_MSB:CTRL_PRE_LSB] = c.pre;
    w[CTRL_ONESHOT]              = c.oneshot;
    w[CTRL_IEN]                  = c.ien;
    w[CTRL_CNT_EN]               = c.cnt_en;
    return w;
  endfunction

endpackage

// File: rtl/pit_mch_chan.sv
// One timer channel: control/modulo registers, prescaler, modulo counter,
// sticky flag and registered interrupt.
module pit_mch_chan
  import pit_mch_pkg::*;
#(
  parameter int   COUNT_SIZE  = 16,
  parameter logic NO_PRESCALE = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_b,
  input  logic [1:0]            ctrl_we,
  input  ch_ctrl_t              ctrl_wr,
  input  logic                  mod_we,
  input  logic [COUNT_SIZE-1:0] mod_wr,
  input  logic                  start,
  input  logic                  flag_clr,
  output ch_ctrl_t              ctrl,
  output logic [COUNT_SIZE-1:0] mod,
  output logic [COUNT_SIZE-1:0] cnt,
  output logic                  flag,
  output logic                  irq
);

  ch_ctrl_t              ctrl_q, ctrl_d;
  logic [COUNT_SIZE-1:0] mod_q, mod_d, cnt_q, cnt_d, term;
  logic [15:0]           presc_q, presc_d, presc_max;
  logic                  flag_q, flag_d, irq_q, irq_d;
  logic                  tick, wrap;

  always_comb begin
    // A zero modulo selects the full 2^COUNT_SIZE period
    term      = (mod_q == '0) ? '1 : mod_q - COUNT_SIZE'(1);
    presc_max = 16'((17'd1 << ctrl_q.pre) - 17'd1);
    tick      = NO_PRESCALE || (presc_q == presc_max);
    wrap      = 1'b0;
    cnt_d     = '0;
    presc_d   = '0;
    if (ctrl_q.cnt_en) begin
      presc_d = tick ? 16'd0 : presc_q + 16'd1;
      cnt_d   = cnt_q;
      if (tick) begin
        if (cnt_q >= term) begin
          cnt_d = '0;
          wrap  = 1'b1;
        end else begin
          cnt_d = cnt_q + COUNT_SIZE'(1);
        end
      end
    end

    flag_d = (flag_q & ~flag_clr) | wrap;
    irq_d  = flag_q & ctrl_q.ien;

    ctrl_d = ctrl_q;
    if (wrap && ctrl_q.oneshot) ctrl_d.cnt_en = 1'b0;
    if (start)                  ctrl_d.cnt_en = 1'b1;
    // A CTRL write to the low lane overrides the one-shot stop on the same edge
    if (ctrl_we[0]) begin
      ctrl_d.oneshot = ctrl_wr.oneshot;
      ctrl_d.ien     = ctrl_wr.ien;
      ctrl_d.cnt_en  = ctrl_wr.cnt_en;
    end
    if (ctrl_we[1] && !NO_PRESCALE) ctrl_d.pre = ctrl_wr.pre;

    mod_d = mod_we ? mod_wr : mod_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      ctrl_q  <= '0;
      mod_q   <= '0;
      cnt_q   <= '0;
      presc_q <= '0;
      flag_q  <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      ctrl_q  <= ctrl_d;
      mod_q   <= mod_d;
      cnt_q   <= cnt_d;
      presc_q <= presc_d;
      flag_q  <= flag_d;
      irq_q   <= irq_d;
    end
  end

  assign ctrl = ctrl_q;
  assign mod  = mod_q;
  assign cnt  = cnt_q;
  assign flag = flag_q;
  assign irq  = irq_q;

endmodule

// File: rtl/pit_mch_timer.sv
// Multi-channel PIT: register decode, byte-lane merge and read mux around
// NUM_CH independent timer channels, plus the combined interrupt.
module pit_mch_timer
  import pit_mch_pkg::*;
#(
  parameter int   NUM_CH      = 4,
  parameter int   COUNT_SIZE  = 16,
  parameter logic NO_PRESCALE = 1'b0,
  parameter int   DWIDTH      = 16,
  parameter int   AWIDTH      = 5
) (
  input  logic              bus_clk,
  input  logic              sync_rst_b,
  input  logic [AWIDTH-1:0] addr,
  input  logic              wr_en,
  input  logic [1:0]        byte_sel,
  input  logic [DWIDTH-1:0] write_bus,
  output logic [DWIDTH-1:0] read_bus,
  output logic [NUM_CH-1:0] ch_irq_o,
  output logic              pit_irq_o
);

  ch_ctrl_t              ctrl_s [NUM_CH];
  logic [COUNT_SIZE-1:0] mod_s  [NUM_CH];
  logic [COUNT_SIZE-1:0] cnt_s  [NUM_CH];
  logic [NUM_CH-1:0]     flag_s, en_s, ien_s, irq_s;
  logic                  gstat_hit, gstart_hit;
  logic                  pit_irq_q, pit_irq_d;
  ch_ctrl_t              ctrl_wr;
  logic [15:0]           rd_data;

  function automatic logic [15:0] lane_merge(input logic [15:0] old_w,
                                             input logic [15:0] new_w,
                                             input logic [1:0]  bsel);
    logic [15:0] w;
    w = old_w;
    if (bsel[0]) w[7:0]  = new_w[7:0];
    if (bsel[1]) w[15:8] = new_w[15:8];
    return w;
  endfunction

  assign gstat_hit  = wr_en && (addr == AWIDTH'(GSTAT_ADR))  && byte_sel[0];
  assign gstart_hit = wr_en && (addr == AWIDTH'(GSTART_ADR)) && byte_sel[0];
  assign ctrl_wr    = {write_bus[CTRL_PRE_MSB:CTRL_PRE_LSB], write_bus[CTRL_ONESHOT],
                       write_bus[CTRL_IEN], write_bus[CTRL_CNT_EN]};

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic                  ctrl_hit, mod_hit;
    logic [COUNT_SIZE-1:0] mod_wr;

    assign ctrl_hit = wr_en && (addr == AWIDTH'(CH_BASE + CH_STRIDE*i));
    assign mod_hit  = wr_en && (addr == AWIDTH'(CH_BASE + CH_STRIDE*i + 1)) && (|byte_sel);
    assign mod_wr   = COUNT_SIZE'(lane_merge(16'(mod_s[i]), write_bus, byte_sel));

    pit_mch_chan #(
      .COUNT_SIZE (COUNT_SIZE),
      .NO_PRESCALE(NO_PRESCALE)
    ) u_chan (
      .clk     (bus_clk),
      .rst_b   (sync_rst_b),
      .ctrl_we ({2{ctrl_hit}} & byte_sel),
      .ctrl_wr (ctrl_wr),
      .mod_we  (mod_hit),
      .mod_wr  (mod_wr),
      .start   (gstart_hit && write_bus[i]),
      .flag_clr(gstat_hit && write_bus[i]),
      .ctrl    (ctrl_s[i]),
      .mod     (mod_s[i]),
      .cnt     (cnt_s[i]),
      .flag    (flag_s[i]),
      .irq     (irq_s[i])
    );

    assign en_s[i]  = ctrl_s[i].cnt_en;
    assign ien_s[i] = ctrl_s[i].ien;
  end

  always_comb begin
    rd_data = '0;
    if (addr == AWIDTH'(GSTAT_ADR))  rd_data = 16'(flag_s);
    if (addr == AWIDTH'(GSTART_ADR)) rd_data = 16'(en_s);
    for (int i = 0; i < NUM_CH; i++) begin
      if (addr == AWIDTH'(CH_BASE + CH_STRIDE*i))     rd_data = ctrl_to_word(ctrl_s[i]);
      if (addr == AWIDTH'(CH_BASE + CH_STRIDE*i + 1)) rd_data = 16'(mod_s[i]);
      if (addr == AWIDTH'(CH_BASE + CH_STRIDE*i + 2)) rd_data = 16'(cnt_s[i]);
    end
    pit_irq_d = |(flag_s & ien_s);
  end

  always_ff @(posedge bus_clk) begin
    if (!sync_rst_b) pit_irq_q <= 1'b0;
    else             pit_irq_q <= pit_irq_d;
  end

  assign read_bus  = DWIDTH'(rd_data);
  assign ch_irq_o  = irq_s;
  assign pit_irq_o = pit_irq_q;

endmodule

// File: tb/tb_pit_mch_timer.sv
// Bench for pit_mch_timer: directed tables, hand sequences for corner cases
// and a randomized run against a behavioural model of the register map.
module tb_pit_mch_timer;

  localparam int NCH = 4;
  localparam int CS  = 4;
  localparam int AW  = 5;

  logic            bus_clk = 1'b0;
  logic            sync_rst_b = 1'b0;
  logic [AW-1:0]   addr = '0;
  logic            wr_en = 1'b0;
  logic [1:0]      byte_sel = '0;
  logic [15:0]     write_bus = '0;
  logic [15:0]     read_bus;
  logic [NCH-1:0]  ch_irq_o;
  logic            pit_irq_o;

  int checks = 0;
  int errors = 0;

  pit_mch_timer #(
    .NUM_CH(NCH), .COUNT_SIZE(CS), .NO_PRESCALE(1'b0), .DWIDTH(16), .AWIDTH(AW)
  ) dut (
    .bus_clk(bus_clk), .sync_rst_b(sync_rst_b), .addr(addr), .wr_en(wr_en),
    .byte_sel(byte_sel), .write_bus(write_bus), .read_bus(read_bus),
    .ch_irq_o(ch_irq_o), .pit_irq_o(pit_irq_o)
  );

  always #10 bus_clk = ~bus_clk;

  // Behavioural model state, one entry per channel
  int m_cnt[NCH], m_presc[NCH], m_mod[NCH], m_pre[NCH], m_os[NCH];
  int m_ien[NCH], m_en[NCH], m_flag[NCH], m_irq[NCH];
  int m_pit;

  function automatic void model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_cnt[i] = 0; m_presc[i] = 0; m_mod[i] = 0; m_pre[i] = 0; m_os[i] = 0;
      m_ien[i] = 0; m_en[i] = 0; m_flag[i] = 0; m_irq[i] = 0;
    end
    m_pit = 0;
  endfunction

  function automatic int model_read(input int a);
    int v = 0;
    if (a == 0) for (int i = 0; i < NCH; i++) v |= m_flag[i] << i;
    if (a == 1) for (int i = 0; i < NCH; i++) v |= m_en[i] << i;
    for (int i = 0; i < NCH; i++) begin
      if (a == 2 + 3*i) v = (m_pre[i] << 8) | (m_os[i] << 4) | (m_ien[i] << 1) | m_en[i];
      if (a == 3 + 3*i) v = m_mod[i];
      if (a == 4 + 3*i) v = m_cnt[i];
    end
    return v;
  endfunction

  function automatic int model_irq();
    int v = 0;
    for (int i = 0; i < NCH; i++) v |= m_irq[i] << i;
    return v;
  endfunction

  function automatic void model_step(input int a, input bit we, input int bs, input int wd);
    int pit_n = 0;
    for (int i = 0; i < NCH; i++) if (m_flag[i] != 0 && m_ien[i] != 0) pit_n = 1;
    for (int i = 0; i < NCH; i++) begin
      int ca = 2 + 3*i;
      bit wrap = 0;
      int cnt_n = 0;
      int presc_n = 0;
      int flag_n, en_n;
      if (m_en[i] != 0) begin
        if (m_presc[i] == (1 << m_pre[i]) - 1) begin
          int period = (m_mod[i] == 0) ? (1 << CS) : m_mod[i];
          if (m_cnt[i] >= period - 1) wrap = 1;
          else cnt_n = m_cnt[i] + 1;
        end else begin
          presc_n = m_presc[i] + 1;
          cnt_n = m_cnt[i];
        end
      end
      m_irq[i] = m_flag[i] & m_ien[i];
      flag_n = m_flag[i];
      if (we && a == 0 && (bs & 1) != 0 && ((wd >> i) & 1) != 0) flag_n = 0;
      if (wrap) flag_n = 1;
      en_n = m_en[i];
      if (wrap && m_os[i] != 0) en_n = 0;
      if (we && a == 1 && (bs & 1) != 0 && ((wd >> i) & 1) != 0) en_n = 1;
      if (we && a == ca) begin
        if ((bs & 1) != 0) begin
          m_os[i] = (wd >> 4) & 1; m_ien[i] = (wd >> 1) & 1; en_n = wd & 1;
        end
        if ((bs & 2) != 0) m_pre[i] = (wd >> 8) & 15;
      end
      if (we && a == ca + 1) begin
        int v = m_mod[i];
        if ((bs & 1) != 0) v = (v & ~32'hFF) | (wd & 32'hFF);
        if ((bs & 2) != 0) v = (v & 32'hFF) | (wd & 32'hFF00);
        m_mod[i] = v & ((1 << CS) - 1);
      end
      m_cnt[i] = cnt_n; m_presc[i] = presc_n; m_flag[i] = flag_n; m_en[i] = en_n;
    end
    m_pit = pit_n;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input int a, input bit we, input int bs, input int wd);
    addr = AW'(a); wr_en = we; byte_sel = 2'(bs); write_bus = 16'(wd);
    @(posedge bus_clk);
    model_step(a, we, bs, wd);
    #1;
    wr_en = 1'b0;
  endtask

  task automatic idle();
    step(0, 1'b0, 0, 0);
  endtask

  task automatic peek(input int a, output int v);
    addr = AW'(a);
    #1;
    v = int'(read_bus);
  endtask

  task automatic check_all(input string tag);
    int v;
    chk($sformatf("%s ch_irq", tag), int'(ch_irq_o), model_irq());
    chk($sformatf("%s pit_irq", tag), int'(pit_irq_o), m_pit);
    for (int a = 0; a < 14; a++) begin
      peek(a, v);
      chk($sformatf("%s rd[%0d]", tag, a), v, model_read(a));
    end
    peek(21, v);
    chk($sformatf("%s rd_unmapped", tag), v, 0);
  endtask

  // A write is presented during the reset edge; reset must win
  task automatic do_reset();
    addr = AW'(3); wr_en = 1'b1; byte_sel = 2'b11; write_bus = 16'h0009; sync_rst_b = 1'b0;
    @(posedge bus_clk);
    model_reset();
    #1;
    sync_rst_b = 1'b1; wr_en = 1'b0;
  endtask

  typedef struct {
    int a; bit we; int bs; int wd;
    int cnt0; int flag0; int irq0;
  } vec_t;

  vec_t tbl[14];

  initial begin
    int v, v2;

    tbl[0]  = '{3, 1, 3, 4, 0, 0, 0};
    tbl[1]  = '{2, 1, 3, 3, 0, 0, 0};
    tbl[2]  = '{0, 0, 0, 0, 1, 0, 0};
    tbl[3]  = '{0, 0, 0, 0, 2, 0, 0};
    tbl[4]  = '{0, 0, 0, 0, 3, 0, 0};
    tbl[5]  = '{0, 0, 0, 0, 0, 1, 0};
    tbl[6]  = '{0, 0, 0, 0, 1, 1, 1};
    tbl[7]  = '{0, 0, 0, 0, 2, 1, 1};
    tbl[8]  = '{0, 0, 0, 0, 3, 1, 1};
    tbl[9]  = '{0, 1, 1, 1, 0, 1, 1};
    tbl[10] = '{0, 1, 1, 1, 1, 0, 1};
    tbl[11] = '{0, 0, 0, 0, 2, 0, 0};
    tbl[12] = '{0, 0, 0, 0, 3, 0, 0};
    tbl[13] = '{0, 0, 0, 0, 0, 1, 0};

    // Reset clears everything programmed before it
    do_reset();
    step(2, 1, 3, 'h0003);
    step(3, 1, 3, 5);
    idle();
    do_reset();
    peek(2, v); chk("reset ctrl0", v, 0);
    peek(3, v); chk("reset mod0", v, 0);
    peek(4, v); chk("reset cnt0", v, 0);
    peek(1, v); chk("reset gstart", v, 0);
    chk("reset ch_irq", int'(ch_irq_o), 0);
    chk("reset pit_irq", int'(pit_irq_o), 0);
    idle();
    check_all("post_reset");

    // Periodic channel 0 with W1C race, table driven
    for (int k = 0; k < 14; k++) begin
      step(tbl[k].a, tbl[k].we, tbl[k].bs, tbl[k].wd);
      peek(4, v); chk($sformatf("tbl%0d cnt0", k), v, tbl[k].cnt0);
      peek(0, v); chk($sformatf("tbl%0d flag0", k), v & 1, tbl[k].flag0);
      chk($sformatf("tbl%0d irq0", k), int'(ch_irq_o[0]), tbl[k].irq0);
      chk($sformatf("tbl%0d pit", k), int'(pit_irq_o), tbl[k].irq0);
    end
    idle();
    check_all("periodic");

    // Prescaled one-shot on channel 1
    do_reset();
    step(6, 1, 3, 3);
    step(5, 1, 3, 'h0213);
    for (int k = 1; k <= 13; k++) begin
      idle();
      if (k == 4)  begin peek(7, v); chk("oneshot cnt1@4", v, 1); end
      if (k == 11) begin peek(0, v); chk("oneshot gstat@11", v, 0); end
      if (k == 12) begin
        peek(0, v); chk("oneshot gstat@12", v, 2);
        peek(5, v); chk("oneshot ctrl1@12", v, 'h0212);
        peek(7, v); chk("oneshot cnt1@12", v, 0);
      end
      if (k == 13) chk("oneshot irq@13", int'(ch_irq_o), 2);
    end
    repeat (8) idle();
    peek(7, v); chk("oneshot cnt1 held", v, 0);
    idle();
    check_all("oneshot");

    // Synchronised start of channels 0 and 2
    do_reset();
    step(3, 1, 3, 6);
    step(9, 1, 3, 6);
    step(2, 1, 3, 'h0002);
    step(8, 1, 3, 'h0002);
    step(1, 1, 3, 'h0005);
    for (int k = 1; k <= 7; k++) begin
      idle();
      peek(4, v); peek(10, v2);
      chk($sformatf("sync cnt0@%0d", k), v, k % 6);
      chk($sformatf("sync cnt2@%0d", k), v2, k % 6);
      if (k == 6) begin peek(0, v); chk("sync gstat@6", v, 5); end
      if (k == 7) begin
        chk("sync ch_irq@7", int'(ch_irq_o), 5);
        chk("sync pit@7", int'(pit_irq_o), 1);
      end
    end

    // Zero modulo gives a full period; a modulo of one with repeated W1C (set wins)
    do_reset();
    step(11, 1, 3, 'h0001);
    for (int k = 1; k <= 16; k++) begin
      idle();
      if (k == 15) begin
        peek(13, v); chk("mod0 cnt3@15", v, 15);
        peek(0, v);  chk("mod0 gstat@15", v, 0);
      end
      if (k == 16) begin
        peek(13, v); chk("mod0 cnt3@16", v, 0);
        peek(0, v);  chk("mod0 gstat@16", v, 8);
      end
    end
    step(12, 1, 3, 1);
    for (int k = 0; k < 4; k++) begin
      step(0, 1, 1, 8);
      peek(0, v);  chk($sformatf("mod1 gstat%0d", k), v, 8);
      peek(13, v); chk($sformatf("mod1 cnt3_%0d", k), v, 0);
    end
    step(11, 1, 3, 0);
    step(0, 1, 1, 8);
    peek(0, v); chk("mod1 cleared", v, 0);

    // Modulo shrinks below the running count
    do_reset();
    step(3, 1, 3, 10);
    step(2, 1, 3, 'h0101);
    repeat (14) idle();
    peek(4, v); chk("shrink cnt0 before", v, 7);
    step(3, 1, 3, 2);
    peek(4, v); chk("shrink cnt0 at write", v, 7);
    peek(0, v); chk("shrink gstat at write", v, 0);
    idle();
    peek(4, v); chk("shrink cnt0 wrapped", v, 0);
    peek(0, v); chk("shrink gstat wrapped", v, 1);

    // Byte lanes
    do_reset();
    step(3, 1, 3, 5);
    step(3, 1, 1, 'hFF0A);
    peek(3, v); chk("lane mod lo", v, 'hA);
    step(3, 1, 2, 'hFF03);
    peek(3, v); chk("lane mod hi only", v, 'hA);
    step(5, 1, 3, 'h0302);
    peek(5, v); chk("lane ctrl full", v, 'h0302);
    step(5, 1, 2, 'h0001);
    peek(5, v); chk("lane ctrl hi", v, 'h0002);
    step(5, 1, 1, 'h0F13);
    peek(5, v); chk("lane ctrl lo", v, 'h0013);
    step(1, 1, 2, 'h0001);
    peek(1, v); chk("lane gstart hi ignored", v, 'h0002);
    idle();
    check_all("lanes");

    // Randomized traffic against the model
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      int a  = $urandom_range(0, 17);
      bit we = ($urandom_range(0, 2) == 0);
      int bs = $urandom_range(0, 3);
      int wd = int'($urandom);
      if (a >= 2 && a < 14 && (a - 2) % 3 == 0) wd &= 'h0313;
      if (a == 0 && $urandom_range(0, 3) != 0) we = 1'b0;
      if (n % 500 == 499) do_reset();
      else step(a, we, bs, wd);
      check_all($sformatf("rnd%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
